regfile_sb: RTL

Parametrised integer register file for the pipelined core, with NRD combinational read ports and one write port.
- Same-cycle write-to-read bypass.
- Per-register pending-write scoreboard: counts in-flight writers and raises an issue stall on RAW or write-count overflow hazards.
- Sits between decode/issue (reads, scoreboard set) and writeback (write, scoreboard clear).

---
 rtl/rf_pkg.sv | 18 +
 rtl/regfile_sb_counter.sv | 37 +++
 rtl/regfile_sb.sv | 98 +++++++++
 3 files changed

// File: rtl/rf_pkg.sv
// Shared constants and helpers for the integer register file and its scoreboard.
package rf_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;
  localparam int REG_ZERO = 0;

  // Address width for a register file of nreg entries (nreg is a power of two).
  function automatic int addr_w(input int nreg);
    return $clog2(nreg);
  endfunction

  // Low bit of field k in a packed port built from fields of width w.
  function automatic int field_lo(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/regfile_sb_counter.sv
// Pending-writer counter for one register: counts issued-but-not-written-back
// instructions. It never wraps above the top value or below zero.
module sb_counter
  import rf_pkg::*;
#(
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          dec,
  input  logic          clr,
  output logic [CW-1:0] cnt,
  output logic          nz
);

  localparam logic [CW-1:0] CMAX = '1;

  logic dec_ok;

  assign nz     = (cnt != '0);
  assign dec_ok = dec & nz;

  // Clear wins; a simultaneous inc and dec cancel out, which keeps a full
  // counter full when issue and writeback hit the same register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (inc && !dec_ok && cnt != CMAX)
      cnt <= cnt + CW'(1);
    else if (dec_ok && !inc)
      cnt <= cnt - CW'(1);
  end

endmodule

// File: rtl/regfile_sb.sv
// Integer register file with NRD combinational read ports, one write port,
// optional write-to-read bypass and a per-register pending-write scoreboard
// that stalls issue on RAW hazards or when a register's writer count is full.
module regfile_sb
  import rf_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREG   = NREG_DEF,
  parameter int NRD    = 2,
  parameter int BYPASS = 1,
  parameter int CW     = 2,
  localparam int AW    = addr_w(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [XLEN-1:0]   wr_data,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  input  logic              iss_valid,
  input  logic [AW-1:0]     iss_rd,
  input  logic [NRD*AW-1:0] iss_rs,
  output logic              iss_stall,
  input  logic              flush,
  output logic [NREG-1:0]   busy_vec
);

  localparam logic [CW-1:0] CMAX = '1;

  logic [XLEN-1:0] rf  [NREG];
  logic [CW-1:0]   cnt [NREG];
  logic            issue_fire;
  logic            hazard;

  // Architectural storage; entry 0 is never written so it stays zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++)
        rf[i] <= '0;
    end else if (wr_en && wr_addr != AW'(REG_ZERO)) begin
      rf[wr_addr] <= wr_data;
    end
  end

  // Read ports: x0 reads zero, a same-cycle write is forwarded when bypass is on.
  always_comb begin
    logic [AW-1:0] ra;
    rd_data = '0;
    ra      = '0;
    for (int k = 0; k < NRD; k++) begin
      ra = rd_addr[field_lo(k, AW) +: AW];
      if (ra == AW'(REG_ZERO))
        rd_data[k*XLEN +: XLEN] = '0;
      else if (BYPASS != 0 && wr_en && wr_addr == ra)
        rd_data[k*XLEN +: XLEN] = wr_data;
      else
        rd_data[k*XLEN +: XLEN] = rf[ra];
    end
  end

  // Issue hazards: a pending source (unless its last writer completes now and
  // is forwarded) or a destination whose writer count cannot grow.
  always_comb begin
    logic [AW-1:0] rs;
    hazard = 1'b0;
    rs     = '0;
    for (int k = 0; k < NRD; k++) begin
      rs = iss_rs[field_lo(k, AW) +: AW];
      if (rs != AW'(REG_ZERO) && cnt[rs] != '0 &&
          !(BYPASS != 0 && cnt[rs] == CW'(1) && wr_en && wr_addr == rs))
        hazard = 1'b1;
    end
    if (iss_rd != AW'(REG_ZERO) && cnt[iss_rd] == CMAX &&
        !(wr_en && wr_addr == iss_rd))
      hazard = 1'b1;
    iss_stall = iss_valid & hazard;
  end

  assign issue_fire = iss_valid & ~iss_stall & (iss_rd != AW'(REG_ZERO));

  assign cnt[0]      = '0;
  assign busy_vec[0] = 1'b0;

  // One pending-writer counter per non-zero register.
  for (genvar i = 1; i < NREG; i++) begin : g_sb
    sb_counter #(.CW(CW)) u_cnt (
      .clk (clk),
      .rst (rst),
      .inc (issue_fire && iss_rd == AW'(i)),
      .dec (wr_en && wr_addr == AW'(i)),
      .clr (flush),
      .cnt (cnt[i]),
      .nz  (busy_vec[i])
    );
  end

endmodule
